instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Program-flow front end of the 8-bit core: owns the program counter (PC), fetches 16-bit
//  instruction words from program memory over a req/ack handshake, and holds the fetched word
//  in an instruction register that drives the combinational instruction decoder.
//  Consumes the decoder's PC-control outputs (cnt_wr_en, add_offset, literal_adr) to compute
//  the next PC. Issues exec_en, the single-cycle strobe that qualifies register/status writes.
// PARAMETERS
//  PC_WIDTH           8        program counter / program memory address width
//  PROGRAM_DataWidth  16       instruction word width
//  DataWidth          8        literal/offset width from decoder (two's complement for offsets)
//  NOP_INSTR          16'h0000 instruction register value after reset (opcode NOP)
// PORTS
//  clk          in   1                  single core clock, all state on rising edge
//  reset_n      in   1                  synchronous reset, active low
//  run          in   1                  1 = fetch/execute, 0 = halt after current instruction
//  mem_req      out  1                  program memory read request
//  mem_adr      out  PC_WIDTH           program memory address (== pc)
//  mem_data     in   PROGRAM_DataWidth  read data, valid while mem_ack=1
//  mem_ack      in   1                  memory acknowledge, data valid this cycle
//  instruction  out  PROGRAM_DataWidth  instruction register, feeds decoder
//  exec_en      out  1                  1-cycle execute strobe (gates wr_en/stat_wr_en downstream)
//  cnt_wr_en    in   1                  from decoder: load PC instead of increment
//  add_offset   in   1                  from decoder: 1 = PC-relative, 0 = absolute load
//  literal_adr  in   DataWidth          from decoder: target address or signed offset
//  pc           out  PC_WIDTH           current program counter
//  busy         out  1                  1 whenever state != S_IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge, any state): pc=0, state=S_IDLE, instruction=NOP_INSTR,
//   mem_req=0, exec_en=0, busy=0. Reset during an outstanding request aborts it; mem_req
//   low from the next cycle; a later mem_ack is ignored.
//  States: S_IDLE, S_REQ, S_EXEC (registered, one-hot or binary free choice).
//   S_IDLE: mem_req=0, exec_en=0. run=1 -> S_REQ next cycle.
//   S_REQ : mem_req=1, mem_adr=pc held stable until ack. mem_ack=1 -> instruction<=mem_data,
//           -> S_EXEC. mem_ack=0 -> stay (unbounded wait states, no timeout). run is not
//           sampled here; a started fetch always completes.
//   S_EXEC: exactly one cycle, exec_en=1, instruction stable, decoder outputs sampled at the
//           closing edge. Next PC (all arithmetic modulo 2^PC_WIDTH, wrap-around silent):
//             cnt_wr_en=0                -> pc+1
//             cnt_wr_en=1, add_offset=0  -> literal_adr zero-extended/truncated to PC_WIDTH
//             cnt_wr_en=1, add_offset=1  -> pc + sign_extend(literal_adr) (relative to the
//                                           branch's own address; offset 0 = self-loop)
//           Then run=1 -> S_REQ, run=0 -> S_IDLE (PC already updated).
//  mem_ack outside S_REQ is ignored. mem_data sampled only when mem_req=1 and mem_ack=1.
//  Latency: zero-wait memory (ack in first S_REQ cycle) = 2 cycles/instruction; each wait
//   state adds 1. First mem_req 1 cycle after run rises from S_IDLE.
//  instruction changes only on accepted ack or reset; exec_en never asserts twice per fetch.
//  PC=2^PC_WIDTH-1 with increment -> 0; relative branch below 0 wraps to top of memory.
// TESTING
//  1 reset_n=0 mid-S_REQ, mem_ack=1 same cycle -> pc=0, instruction=16'h0000, mem_req=0, exec_en=0.
//  2 run=1, zero-wait memory, 3x NOP -> mem_adr 0,1,2 on alternate cycles, exec_en every 2nd cycle.
//  3 ack delayed 3 cycles at pc=5 -> mem_req/mem_adr=5 held 4 cycles, one exec_en, then pc=6.
//  4 GOTO 8'h40 at pc=3 (cnt_wr_en=1, add_offset=0) -> next mem_adr=8'h40.
//  5 IFZ taken at pc=8'h10, literal 8'hFE -> pc=8'h0E; not taken -> 8'h11; pc=8'hFF, offset 8'h02 -> 8'h01.
//  6 run=0 during S_REQ -> fetch completes, one exec_en, S_IDLE, busy=0, pc advanced by one.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: program-flow front end of the 8-bit core.
// Owns the program counter, fetches instruction words from program memory over a
// req/ack handshake, holds the fetched word for the decoder and issues the
// single-cycle execute strobe. The next PC comes from the decoder's PC-control
// inputs, which are sampled at the edge that closes the execute cycle.
module instr_fetch #(
    parameter int                           PC_WIDTH          = 8,
    parameter int                           PROGRAM_DataWidth = 16,
    parameter int                           DataWidth         = 8,
    parameter logic [PROGRAM_DataWidth-1:0] NOP_INSTR         = 16'h0000
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_run,
    output logic                         o_mem_req,
    output logic [PC_WIDTH-1:0]          o_mem_adr,
    input  logic [PROGRAM_DataWidth-1:0] i_mem_data,
    input  logic                         i_mem_ack,
    output logic [PROGRAM_DataWidth-1:0] o_instruction,
    output logic                         o_exec_en,
    input  logic                         i_cnt_wr_en,
    input  logic                         i_add_offset,
    input  logic [DataWidth-1:0]         i_literal_adr,
    output logic [PC_WIDTH-1:0]          o_pc,
    output logic                         o_busy
);

    // Width used to sign/zero-extend the literal before trimming it to the PC width,
    // so that both wider and narrower literals are handled by one expression.
    localparam int EXT_W = (PC_WIDTH > DataWidth) ? PC_WIDTH : DataWidth;

    localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           w_ack_take;
    logic                           w_in_exec;

    logic [PC_WIDTH-1:0]            r_pc;
    logic [PC_WIDTH-1:0]            w_pc_nxt;
    logic [PROGRAM_DataWidth-1:0]   r_instruction;
    logic                           r_mem_req;
    logic                           r_exec_en;
    logic                           r_busy;

    logic [EXT_W-1:0]               w_lit_sext;
    logic [EXT_W-1:0]               w_lit_zext;
    logic [PC_WIDTH-1:0]            w_lit_rel;
    logic [PC_WIDTH-1:0]            w_lit_abs;

    // Literal extension: signed view for relative branches, unsigned view for absolute loads.
    always_comb begin
        w_lit_sext = EXT_W'($signed(i_literal_adr));
        w_lit_zext = EXT_W'(i_literal_adr);
        w_lit_rel  = w_lit_sext[PC_WIDTH-1:0];
        w_lit_abs  = w_lit_zext[PC_WIDTH-1:0];
    end

    // Next-state logic; an ack is only accepted while a request is outstanding.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_take  = 1'b0;
        w_in_exec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                // run is deliberately ignored: a started fetch always completes.
                if (i_mem_ack) begin
                    w_state_nxt = S_EXEC;
                    w_ack_take  = 1'b1;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_EXEC: begin
                w_in_exec = 1'b1;
                if (i_run) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a quiet idle state.
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next-PC selection, applied only at the edge closing the execute cycle.
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_in_exec) begin
            if (!i_cnt_wr_en) begin
                w_pc_nxt = r_pc + PC_ONE;
            end else if (i_add_offset) begin
                // Relative to the branch's own address; wraps silently.
                w_pc_nxt = r_pc + w_lit_rel;
            end else begin
                w_pc_nxt = w_lit_abs;
            end
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Program counter register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pc <= PC_ZERO;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    // Instruction register: loads only on an accepted ack, otherwise holds.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_instruction <= NOP_INSTR;
        end else if (w_ack_take) begin
            r_instruction <= i_mem_data;
        end else begin
            r_instruction <= r_instruction;
        end
    end

    // Registered handshake/strobe outputs, decoded from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mem_req <= 1'b0;
            r_exec_en <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_mem_req <= (w_state_nxt == S_REQ);
            r_exec_en <= (w_state_nxt == S_EXEC);
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_mem_req     = r_mem_req;
    assign o_mem_adr     = r_pc;
    assign o_pc          = r_pc;
    assign o_instruction = r_instruction;
    assign o_exec_en     = r_exec_en;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a table of fetch records drives a bench-side
// memory/decoder model; fetched words go through a scoreboard queue and are compared
// when the execute strobe appears. Hand sequences cover halt, idle ack and reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_run;
    logic        o_mem_req;
    logic [7:0]  o_mem_adr;
    logic [15:0] i_mem_data;
    logic        i_mem_ack;
    logic [15:0] o_instruction;
    logic        o_exec_en;
    logic        i_cnt_wr_en;
    logic        i_add_offset;
    logic [7:0]  i_literal_adr;
    logic [7:0]  o_pc;
    logic        o_busy;

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0] sb[$];

    typedef struct {
        logic [7:0]  pc;      // expected fetch address
        int          waits;   // wait states before ack
        logic [15:0] data;    // instruction word returned
        logic        cnt;     // decoder cnt_wr_en
        logic        add;     // decoder add_offset
        logic [7:0]  lit;     // decoder literal_adr
        logic        run_on;  // keep run high during this fetch
    } vec_t;

    vec_t vecs[19];

    instr_fetch dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_run         (i_run),
        .o_mem_req     (o_mem_req),
        .o_mem_adr     (o_mem_adr),
        .i_mem_data    (i_mem_data),
        .i_mem_ack     (i_mem_ack),
        .o_instruction (o_instruction),
        .o_exec_en     (o_exec_en),
        .i_cnt_wr_en   (i_cnt_wr_en),
        .i_add_offset  (i_add_offset),
        .i_literal_adr (i_literal_adr),
        .o_pc          (o_pc),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete fetch/execute as seen from the memory and decoder side.
    task automatic fetch_one(input vec_t v);
        logic [15:0] exp_instr;
        @(negedge clk);
        chk("req_adr", o_mem_adr, v.pc);
        chk("pc", o_pc, v.pc);
        chk("req", o_mem_req, 1);
        chk("no_exec_in_req", o_exec_en, 0);
        chk("busy", o_busy, 1);
        if (!v.run_on) i_run = 1'b0;
        for (int w = 0; w < v.waits; w++) begin
            i_mem_ack = 1'b0;
            @(negedge clk);
            chk("wait_req", o_mem_req, 1);
            chk("wait_adr", o_mem_adr, v.pc);
            chk("wait_no_exec", o_exec_en, 0);
        end
        i_mem_ack     = 1'b1;
        i_mem_data    = v.data;
        i_cnt_wr_en   = v.cnt;
        i_add_offset  = v.add;
        i_literal_adr = v.lit;
        sb.push_back(v.data);
        @(negedge clk);
        i_mem_ack  = 1'b0;
        i_mem_data = 16'hDEAD;
        chk("exec", o_exec_en, 1);
        chk("exec_no_req", o_mem_req, 0);
        if (sb.size() > 0) begin
            exp_instr = sb.pop_front();
            chk("instr", o_instruction, exp_instr);
        end else begin
            chk("sb_nonempty", 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // pc, waits, data, cnt, add, lit, run_on
        vecs[0]  = '{8'h00, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{8'h01, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{8'h02, 0, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{8'h03, 0, 16'h2840, 1'b1, 1'b0, 8'h40, 1'b1}; // GOTO 0x40
        vecs[4]  = '{8'h40, 2, 16'h2805, 1'b1, 1'b0, 8'h05, 1'b1}; // GOTO 0x05
        vecs[5]  = '{8'h05, 3, 16'hABCD, 1'b0, 1'b0, 8'h00, 1'b1}; // 3 wait states
        vecs[6]  = '{8'h06, 0, 16'h2810, 1'b1, 1'b0, 8'h10, 1'b1};
        vecs[7]  = '{8'h10, 0, 16'h3CFE, 1'b1, 1'b1, 8'hFE, 1'b1}; // IFZ taken -> 0E
        vecs[8]  = '{8'h0E, 1, 16'h2810, 1'b1, 1'b0, 8'h10, 1'b1};
        vecs[9]  = '{8'h10, 0, 16'h3CFE, 1'b0, 1'b1, 8'hFE, 1'b1}; // not taken -> 11
        vecs[10] = '{8'h11, 0, 16'h28FF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[11] = '{8'hFF, 0, 16'h3C02, 1'b1, 1'b1, 8'h02, 1'b1}; // FF+2 -> 01
        vecs[12] = '{8'h01, 0, 16'h28FF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[13] = '{8'hFF, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1}; // increment wraps
        vecs[14] = '{8'h00, 0, 16'h3C00, 1'b1, 1'b1, 8'h00, 1'b1}; // self-loop
        vecs[15] = '{8'h00, 0, 16'h3C80, 1'b1, 1'b1, 8'h80, 1'b1}; // 0-128 -> 80
        vecs[16] = '{8'h80, 0, 16'h3C7F, 1'b1, 1'b1, 8'h7F, 1'b1}; // 80+127 -> FF
        vecs[17] = '{8'hFF, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1}; // -> 00
        vecs[18] = '{8'h00, 1, 16'h5555, 1'b0, 1'b0, 8'h00, 1'b0}; // run drops in REQ

        i_reset_n     = 1'b0;
        i_run         = 1'b0;
        i_mem_ack     = 1'b0;
        i_mem_data    = 16'h0000;
        i_cnt_wr_en   = 1'b0;
        i_add_offset  = 1'b0;
        i_literal_adr = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pc", o_pc, 8'h00);
        chk("rst_instr", o_instruction, 16'h0000);
        chk("rst_req", o_mem_req, 0);
        chk("rst_exec", o_exec_en, 0);
        chk("rst_busy", o_busy, 0);
        i_reset_n = 1'b1;
        @(negedge clk);
        chk("idle_req", o_mem_req, 0);
        chk("idle_busy", o_busy, 0);
        i_run = 1'b1;

        for (int k = 0; k < 19; k++) fetch_one(vecs[k]);

        // Halted after the last fetch: pc advanced by one, back in idle.
        @(negedge clk);
        chk("halt_pc", o_pc, 8'h01);
        chk("halt_req", o_mem_req, 0);
        chk("halt_busy", o_busy, 0);
        chk("halt_exec", o_exec_en, 0);

        // Ack while idle must be ignored.
        i_mem_ack  = 1'b1;
        i_mem_data = 16'h7777;
        repeat (2) @(negedge clk);
        chk("idle_ack_instr", o_instruction, 16'h5555);
        chk("idle_ack_exec", o_exec_en, 0);
        chk("idle_ack_busy", o_busy, 0);
        i_mem_ack = 1'b0;

        // Restart: first request exactly one cycle after run rises.
        i_run = 1'b1;
        @(negedge clk);
        chk("restart_req", o_mem_req, 1);
        chk("restart_adr", o_mem_adr, 8'h01);

        // Reset mid-request with an ack in the same cycle.
        i_reset_n  = 1'b0;
        i_run      = 1'b0;
        i_mem_ack  = 1'b1;
        i_mem_data = 16'hBEEF;
        @(negedge clk);
        chk("mid_rst_pc", o_pc, 8'h00);
        chk("mid_rst_instr", o_instruction, 16'h0000);
        chk("mid_rst_req", o_mem_req, 0);
        chk("mid_rst_exec", o_exec_en, 0);
        chk("mid_rst_busy", o_busy, 0);
        i_reset_n = 1'b1;
        @(negedge clk);
        chk("late_ack_instr", o_instruction, 16'h0000);
        chk("late_ack_exec", o_exec_en, 0);
        chk("late_ack_req", o_mem_req, 0);
        i_mem_ack = 1'b0;
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
